id_ex_hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the ID/EX pipeline register and the front end (PC, IF/ID). It detects load-use hazards, branch redirects and two-phase decode instructions. From these it drives the ID/EX bubble request (`makeMeBubble`, which forces both register addresses to 4'hF), the PC/IF-ID stalls and the IF/ID flush. It sits beside the decode stage, takes register addresses from ID and EX, and also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/id_ex_hazard_ctrl.sv | 74 +++++++
 tb/tb_id_ex_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: ID/EX hazard sequencer (load-use, branch flush, two-phase decode) driving PC/IF-ID stall, IF-ID flush, ID/EX bubble, decode phase and a saturating stall counter
module id_ex_hazard_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int FLUSH_EXTRA = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  idSrcAddr,
  input  logic [3:0]  idDstAddr,
  input  logic        idMultiCycle,
  input  logic        exMemRead,
  input  logic        exRegWrite,
  input  logic [3:0]  exDestAddr,
  input  logic        branchTaken,
  output logic        pcStall,
  output logic        ifIdStall,
  output logic        ifIdFlush,
  output logic        makeMeBubble,
  output logic        multiPhase,
  output logic [15:0] stallCount
);
  typedef enum logic [1:0] {RUN, LSTALL, MULTI, FLUSH} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic luh, stall, bubble, flush, phase;
  assign luh = exMemRead & exRegWrite & (exDestAddr != 4'hF) &
               ((exDestAddr == idSrcAddr) | (exDestAddr == idDstAddr));
  always_comb begin
    state_n = RUN;
    cnt_n = 3'd0;
    stall = 1'b0;
    bubble = 1'b0;
    flush = 1'b0;
    phase = 1'b0;
    if (branchTaken) begin
      flush = 1'b1;
      bubble = 1'b1;
      state_n = FLUSH_EXTRA > 0 ? FLUSH : RUN;
      cnt_n = 3'(FLUSH_EXTRA);
    end else if (state == LSTALL || state == FLUSH) begin
      stall = state == LSTALL;
      flush = state == FLUSH;
      bubble = 1'b1;
      state_n = cnt == 3'd1 ? RUN : state;
      cnt_n = cnt - 3'd1;
    end else if (state == MULTI) begin
      phase = 1'b1;
    end else if (luh) begin
      stall = 1'b1;
      bubble = 1'b1;
      state_n = MEM_LAT > 1 ? LSTALL : RUN;
      cnt_n = 3'(MEM_LAT - 1);
    end else if (idMultiCycle) begin
      stall = 1'b1;
      state_n = MULTI;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= 3'd0;
      stallCount <= 16'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (stall && stallCount != 16'hFFFF) stallCount <= stallCount + 16'd1;
    end
  end
  assign pcStall = stall & ~rst;
  assign ifIdStall = stall & ~rst;
  assign ifIdFlush = flush & ~rst;
  assign makeMeBubble = bubble | rst;
  assign multiPhase = phase & ~rst;
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb_id_ex_hazard_ctrl: directed vector bench for id_ex_hazard_ctrl (MEM_LAT=3/FLUSH_EXTRA=2 and MEM_LAT=1/FLUSH_EXTRA=0)
module tb_id_ex_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] src, dst, dest;
  logic mc, mr, rw, br;
  logic ps_a, is_a, fl_a, bub_a, mp_a, ps_b, is_b, fl_b, bub_b, mp_b;
  logic [15:0] sc_a, sc_b;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] src, dst;
    logic mc, mr, rw;
    logic [3:0] dest;
    logic br;
    logic [4:0] exp;
    logic [15:0] sc;
  } vec_t;
  vec_t vecs[$];

  localparam logic [4:0] NONE = 5'b00000, STALL = 5'b11010, FLSH = 5'b00110,
                         PH1 = 5'b11000, PH2 = 5'b00001, RSTV = 5'b00010;

  id_ex_hazard_ctrl #(.MEM_LAT(3), .FLUSH_EXTRA(2)) dut (
    .clk(clk), .rst(rst), .idSrcAddr(src), .idDstAddr(dst), .idMultiCycle(mc),
    .exMemRead(mr), .exRegWrite(rw), .exDestAddr(dest), .branchTaken(br),
    .pcStall(ps_a), .ifIdStall(is_a), .ifIdFlush(fl_a), .makeMeBubble(bub_a),
    .multiPhase(mp_a), .stallCount(sc_a));

  id_ex_hazard_ctrl #(.MEM_LAT(1), .FLUSH_EXTRA(0)) dut1 (
    .clk(clk), .rst(rst), .idSrcAddr(src), .idDstAddr(dst), .idMultiCycle(mc),
    .exMemRead(mr), .exRegWrite(rw), .exDestAddr(dest), .branchTaken(br),
    .pcStall(ps_b), .ifIdStall(is_b), .ifIdFlush(fl_b), .makeMeBubble(bub_b),
    .multiPhase(mp_b), .stallCount(sc_b));

  always #5 clk = ~clk;

  function automatic logic [4:0] outs_a();
    return {ps_a, is_a, fl_a, bub_a, mp_a};
  endfunction

  function automatic logic [4:0] outs_b();
    return {ps_b, is_b, fl_b, bub_b, mp_b};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, d, input logic m, r, w,
                       input logic [3:0] e, input logic b);
    src = s; dst = d; mc = m; mr = r; rw = w; dest = e; br = b;
  endtask

  task automatic idle();
    drive(4'hF, 4'hF, 0, 0, 0, 4'hF, 0);
  endtask

  task automatic hazard();
    drive(4'h3, 4'hF, 0, 1, 1, 4'h3, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t v(input logic [3:0] s, d, input logic m, r, w,
                             input logic [3:0] e, input logic b,
                             input logic [4:0] x, input logic [15:0] c);
    vec_t t;
    t.src = s; t.dst = d; t.mc = m; t.mr = r; t.rw = w; t.dest = e; t.br = b;
    t.exp = x; t.sc = c;
    return t;
  endfunction

  initial begin
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, NONE, 0));
    vecs.push_back(v(4'h3, 4'hF, 0, 1, 1, 4'h3, 0, STALL, 0));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, STALL, 1));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, STALL, 2));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, NONE, 3));
    vecs.push_back(v(4'hF, 4'hF, 0, 1, 1, 4'hF, 0, NONE, 3));
    vecs.push_back(v(4'h1, 4'h5, 0, 1, 1, 4'h5, 0, STALL, 3));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, STALL, 4));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, STALL, 5));
    vecs.push_back(v(4'h5, 4'hF, 0, 1, 0, 4'h5, 0, NONE, 6));
    vecs.push_back(v(4'hF, 4'hF, 1, 0, 0, 4'hF, 0, PH1, 6));
    vecs.push_back(v(4'hF, 4'hF, 1, 0, 0, 4'hF, 0, PH2, 7));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, NONE, 7));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 1, FLSH, 7));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 7));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 7));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, NONE, 7));
    vecs.push_back(v(4'h3, 4'hF, 0, 1, 1, 4'h3, 1, FLSH, 7));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 7));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 7));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, NONE, 7));
    vecs.push_back(v(4'hF, 4'hF, 1, 0, 0, 4'hF, 0, PH1, 7));
    vecs.push_back(v(4'hF, 4'hF, 1, 0, 0, 4'hF, 1, FLSH, 8));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 8));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 8));
    vecs.push_back(v(4'h3, 4'hF, 1, 1, 1, 4'h3, 0, STALL, 8));
    vecs.push_back(v(4'hF, 4'hF, 1, 0, 0, 4'hF, 0, STALL, 9));
    vecs.push_back(v(4'hF, 4'hF, 1, 0, 0, 4'hF, 0, STALL, 10));
    vecs.push_back(v(4'hF, 4'hF, 1, 0, 0, 4'hF, 0, PH1, 11));
    vecs.push_back(v(4'hF, 4'hF, 1, 0, 0, 4'hF, 0, PH2, 12));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, NONE, 12));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 1, FLSH, 12));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 12));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 1, FLSH, 12));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 12));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, FLSH, 12));
    vecs.push_back(v(4'hF, 4'hF, 0, 0, 0, 4'hF, 0, NONE, 12));

    hazard();
    #2;
    chk("reset_outs_a", outs_a(), RSTV);
    chk("reset_outs_b", outs_b(), RSTV);
    chk("reset_count", sc_a, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    @(negedge clk);
    hazard();
    #2;
    chk("lat1_stall", outs_b(), STALL);
    chk("lat1_count0", sc_b, 0);
    @(negedge clk);
    idle();
    #2;
    chk("lat1_release", outs_b(), NONE);
    chk("lat1_count1", sc_b, 1);
    @(negedge clk);
    drive(4'hF, 4'hF, 0, 0, 0, 4'hF, 1);
    #2;
    chk("fe0_flush", outs_b(), FLSH);
    @(negedge clk);
    idle();
    #2;
    chk("fe0_release", outs_b(), NONE);

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].src, vecs[i].dst, vecs[i].mc, vecs[i].mr, vecs[i].rw,
            vecs[i].dest, vecs[i].br);
      #2;
      chk($sformatf("vec%0d_outs", i), outs_a(), vecs[i].exp);
      chk($sformatf("vec%0d_count", i), sc_a, vecs[i].sc);
    end

    do_reset();
    @(negedge clk);
    hazard();
    #2;
    chk("midrst_stall1", outs_a(), STALL);
    @(negedge clk);
    idle();
    #1;
    chk("midrst_stall2", outs_a(), STALL);
    rst = 1'b1;
    #1;
    chk("midrst_outs", outs_a(), RSTV);
    chk("midrst_count", sc_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_after", outs_a(), NONE);
    chk("midrst_after_count", sc_a, 0);

    @(negedge clk);
    hazard();
    repeat (65540) @(negedge clk);
    idle();
    #2;
    chk("sat_count", sc_a, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("sat_hold", sc_a, 16'hFFFF);
    chk("sat_idle", outs_a(), NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
